// File: rtl/proce_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : proce_data_mem
// Description : Memory-side responder for the Proce core data port.
//               Word-addressed data RAM plus a small memory-mapped IO region
//               (done/result register, LED register). Owns the core's start
//               signal: after reset it sweeps the RAM to zero, then releases
//               the core. It halts the core once the program writes the done
//               register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1   system clock, all state updates on posedge
//   reset      in   1   asynchronous active-low reset
//   MemWrite   in   1   write strobe from Proce
//   DataAdr    in  32   byte address from Proce
//   WriteData  in  32   store data from Proce
//   rd         out 32   combinational read data to Proce
//   start      out  1   run enable to Proce
//   busy       out  1   RAM clear sweep in progress
//   done       out  1   sticky program-finished flag
//   result     out 32   value written to the done register
//   leds       out  8   LED register
//   err        out  1   sticky access-error flag
// ============================================================================
module proce_data_mem #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] IO_BASE  = 32'h0000_0400,
  parameter logic [31:0] DONE_OFS = 32'd0,
  parameter logic [31:0] LED_OFS  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] rd,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [7:0]  leds,
  output logic        err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [31:0] DONE_ADR  = IO_BASE + DONE_OFS;
  localparam logic [31:0] LED_ADR   = IO_BASE + LED_OFS;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [31:0]    result_q, result_d;
  logic [7:0]     leds_q, leds_d;

  // RAM has no reset: the INIT sweep clears it instead.
  logic [31:0]    mem_q [DEPTH];
  logic           ram_we;
  logic [AW-1:0]  ram_idx;
  logic [31:0]    ram_wdata;

  // Address decode
  logic [AW-1:0]  adr_idx;
  logic           hit_ram, hit_done, hit_led, aligned;

  assign adr_idx  = DataAdr[AW+1:2];
  assign hit_ram  = (DataAdr < RAM_BYTES);
  assign hit_done = (DataAdr == DONE_ADR);
  assign hit_led  = (DataAdr == LED_ADR);
  assign aligned  = (DataAdr[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      leds_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      leds_q   <= leds_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= ram_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    result_d  = result_q;
    leds_d    = leds_q;
    ram_we    = 1'b0;
    ram_idx   = adr_idx;
    ram_wdata = WriteData;

    case (state_q)
      ST_INIT: begin
        // Core accesses are ignored here; the port is owned by the sweep.
        ram_we    = 1'b1;
        ram_idx   = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (MemWrite) begin
          // Misalignment takes priority over every other decode.
          if (!aligned) begin
            err_d = 1'b1;
          end else if (hit_ram) begin
            ram_we = 1'b1;
          end else if (hit_led) begin
            leds_d = WriteData[7:0];
          end else if (hit_done) begin
            result_d = WriteData;
            done_d   = 1'b1;
            state_d  = ST_HALT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        // Held until reset; reads remain serviced below.
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Reads return the pre-edge contents, so a write cycle shows the old value.
  always_comb begin
    rd = '0;
    if (state_q != ST_INIT) begin
      if (hit_ram) begin
        rd = mem_q[adr_idx];
      end else if (hit_led) begin
        rd = {24'b0, leds_q};
      end else if (hit_done) begin
        rd = {31'b0, done_q};
      end
    end
  end

  assign start  = (state_q == ST_RUN);
  assign busy   = (state_q == ST_INIT);
  assign done   = done_q;
  assign result = result_q;
  assign leds   = leds_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_proce_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_proce_data_mem
// Description : Self-checking bench for proce_data_mem. A driver issues one
//               access per cycle and pushes the expected outputs for that
//               cycle, taken from a behavioural model, into a queue; a monitor
//               pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proce_data_mem;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] rd;
  logic        start, busy, done, err;
  logic [31:0] result;
  logic [7:0]  leds;

  proce_data_mem #(
    .DEPTH    (DEPTH),
    .IO_BASE  (32'h0000_0400),
    .DONE_OFS (32'd0),
    .LED_OFS  (32'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .rd        (rd),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .leds      (leds),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [7:0]  leds;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // ---------------- behavioural model ----------------
  int          m_init_left;   // clear cycles still owed after reset release
  bit          m_halted, m_done, m_err;
  logic [31:0] m_result;
  logic [7:0]  m_leds;
  logic [31:0] m_mem [DEPTH];

  function automatic void model_reset();
    m_init_left = DEPTH;
    m_halted    = 1'b0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_result    = '0;
    m_leds      = '0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (m_init_left > 0)            return 32'd0;
    if (a < 32'(DEPTH * 4))         return m_mem[a / 4];
    if (a == 32'h404)               return {24'd0, m_leds};
    if (a == 32'h400)               return {31'd0, m_done};
    return 32'd0;
  endfunction

  function automatic void model_edge(input logic we, input logic [31:0] a,
                                     input logic [31:0] wd);
    if (m_init_left > 0) begin
      m_init_left = m_init_left - 1;
      if (m_init_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else if (!m_halted && we) begin
      if (a % 4 != 0)                 m_err = 1'b1;
      else if (a < 32'(DEPTH * 4))    m_mem[a / 4] = wd;
      else if (a == 32'h404)          m_leds = wd[7:0];
      else if (a == 32'h400) begin
        m_result = wd;
        m_done   = 1'b1;
        m_halted = 1'b1;
      end else                        m_err = 1'b1;
    end
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; covers exactly one clock cycle.
  task automatic step(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
    exp_t e;
    MemWrite  = we;
    DataAdr   = a;
    WriteData = wd;
    e.rd     = model_rd(a);
    e.busy   = (m_init_left > 0);
    e.start  = (m_init_left == 0) && !m_halted;
    e.done   = m_done;
    e.err    = m_err;
    e.result = m_result;
    e.leds   = m_leds;
    e.tag    = tag;
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) model_edge(we, a, wd);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 32'h0, "reset_hold");
    step(1'b1, 32'h64, 32'h5, "reset_hold_wr");
    reset = 1'b1;
  endtask

  task automatic rand_step(input string tag);
    logic [31:0] a;
    logic        we;
    int          k;
    k  = $urandom_range(0, 9);
    we = 1'($urandom_range(0, 1));
    case (k)
      0, 1, 2, 3, 4: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      5:             a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      6:             a = 32'h404;
      7:             a = 32'($urandom_range(DEPTH, 255)) * 4;
      8: begin
        a  = 32'h400;
        we = ($urandom_range(0, 40) == 0);
      end
      default:       a = $urandom;
    endcase
    step(we, a, $urandom, tag);
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      tests++;
      if (rd !== cur.rd || start !== cur.start || busy !== cur.busy ||
          done !== cur.done || err !== cur.err || result !== cur.result ||
          leds !== cur.leds) begin
        fails++;
        $display("FAIL %s @%0t: got rd=%h start=%b busy=%b done=%b err=%b result=%h leds=%h, expected rd=%h start=%b busy=%b done=%b err=%b result=%h leds=%h",
                 cur.tag, $time, rd, start, busy, done, err, result, leds,
                 cur.rd, cur.start, cur.busy, cur.done, cur.err, cur.result, cur.leds);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset values, then a full INIT sweep with stray accesses ignored.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) step(1'b1, 32'h300, 32'hFFFF_FFFF, "init_wr_unmapped");
      else if (i == 20) step(1'b1, 32'h66, 32'h1, "init_wr_misaligned");
      else step(1'b0, 32'(i * 4), 32'h0, "init");
    end

    // RUN: freshly cleared RAM.
    step(1'b0, 32'h00, 32'h0, "run_rd_00");
    step(1'b0, 32'h7C, 32'h0, "run_rd_7c");
    step(1'b0, 32'hFC, 32'h0, "run_rd_fc");

    // RAM write, read-during-write shows old value.
    step(1'b1, 32'h64, 32'h0000_0007, "wr_64");
    step(1'b0, 32'h64, 32'h0, "rd_64");
    step(1'b0, 32'h66, 32'h0, "rd_66_ignores_low_bits");

    // LED register.
    step(1'b1, 32'h404, 32'h0000_00A5, "wr_led");
    step(1'b0, 32'h404, 32'h0, "rd_led");

    // Misaligned and unmapped writes.
    step(1'b1, 32'h66, 32'hDEAD_BEEF, "wr_misaligned");
    step(1'b0, 32'h64, 32'h0, "rd_64_after_misaligned");
    step(1'b1, 32'h200, 32'hCAFE_F00D, "wr_unmapped");
    step(1'b0, 32'h200, 32'h0, "rd_unmapped");
    step(1'b1, 32'hFC, 32'h0BAD_0BAD, "wr_ram_top");
    step(1'b0, 32'hFC, 32'h0, "rd_ram_top");

    // Done register halts the core; later writes ignored.
    step(1'b1, 32'h400, 32'h1234_5678, "wr_done");
    step(1'b0, 32'h400, 32'h0, "rd_done");
    step(1'b1, 32'h10, 32'h9, "halt_wr_10");
    step(1'b0, 32'h10, 32'h0, "halt_rd_10");
    step(1'b1, 32'h404, 32'h3C, "halt_wr_led");
    step(1'b0, 32'h404, 32'h0, "halt_rd_led");

    // Reset in HALT: immediate clear, new sweep, RAM back to zero.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h64, 32'h0, "reinit");
    step(1'b0, 32'h64, 32'h0, "rd_64_after_reinit");
    step(1'b0, 32'hFC, 32'h0, "rd_fc_after_reinit");

    // Randomised episodes, each starting with a fresh reset.
    for (int ep = 0; ep < 3; ep++) begin
      apply_reset();
      for (int i = 0; i < DEPTH; i++) rand_step("rand_init");
      for (int i = 0; i < 250; i++) rand_step("rand_run");
    end

    // Reset asserted mid-RUN after random traffic.
    apply_reset();
    for (int i = 0; i < DEPTH + 20; i++) rand_step("rand_after_reset");

    MemWrite = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
